// File: rtl/mac_seq_pkg.sv
// Shared types for the multiply-add sequencing arbiter: FSM states, default width, id width.
package mac_seq_pkg;

  localparam int DW_DEF = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    SEND_C = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5
  } state_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_seq_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
  import mac_seq_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    id,
  output logic             hit
);

  always_comb begin
    logic [IW-1:0] k;
    gnt = '0;
    id  = '0;
    hit = 1'b0;
    k   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = IW'((int'(ptr) + i) % N_REQ);
      if (!hit && req[k]) begin
        hit    = 1'b1;
        gnt[k] = 1'b1;
        id     = k;
      end
    end
  end

endmodule

// File: rtl/mac_seq_arbiter.sv
// Round-robin sharing of one 3-beat a*b+c datapath with a ready/valid response channel.
// Optional MAC_SEQ_ARBITER_STATS_EN adds accepted-response counters stat_done/stat_timeout.
module mac_seq_arbiter
  import mac_seq_pkg::*;
#(
  parameter int  N_REQ   = 4,
  parameter int  DW      = DW_DEF,
  parameter int  TIMEOUT = 8,
  localparam int IW      = id_w(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] op_a,
  input  logic [N_REQ*DW-1:0] op_b,
  input  logic [N_REQ*DW-1:0] op_c,
  output logic [N_REQ-1:0]    gnt,
  output logic                validi,
  output logic [DW-1:0]       data_in,
  input  logic                valido,
  input  logic [DW-1:0]       data_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IW-1:0]       rsp_id,
  output logic [DW-1:0]       rsp_data,
  output logic                rsp_err
`ifdef MAC_SEQ_ARBITER_STATS_EN
  ,
  output logic [31:0]         stat_done,
  output logic [31:0]         stat_timeout
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                       state;
  logic [IW-1:0]                ptr;
  logic [IW-1:0]                win_id;
  logic [N_REQ-1:0]             arb_gnt;
  logic                         arb_hit;
  logic [DW-1:0]                a_q, b_q, c_q;
  logic [TW-1:0]                timer;
  logic                         xfer;
  logic [N_REQ-1:0][DW-1:0]     a_v, b_v, c_v;

  assign a_v = op_a;
  assign b_v = op_b;
  assign c_v = op_c;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .id  (win_id),
    .hit (arb_hit)
  );

  // Grant is visible in the same cycle the request is seen; suppressed while reset is applied.
  assign gnt       = (state == IDLE && rst) ? arb_gnt : '0;
  assign validi    = (state == SEND_A) || (state == SEND_B) || (state == SEND_C);
  assign rsp_valid = (state == RESP);
  assign xfer      = rsp_valid && rsp_ready;

  always_comb begin
    case (state)
      SEND_A:  data_in = a_q;
      SEND_B:  data_in = b_q;
      SEND_C:  data_in = c_q;
      default: data_in = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      timer    <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arb_hit) begin
          a_q    <= a_v[win_id];
          b_q    <= b_v[win_id];
          c_q    <= c_v[win_id];
          rsp_id <= win_id;
          ptr    <= (win_id == IW'(N_REQ - 1)) ? '0 : win_id + IW'(1);
          state  <= SEND_A;
        end
        SEND_A: state <= SEND_B;
        SEND_B: state <= SEND_C;
        SEND_C: begin
          timer <= '0;
          if (valido) begin
            rsp_data <= data_out;
            rsp_err  <= 1'b0;
            state    <= RESP;
          end else begin
            state    <= WAIT;
          end
        end
        // timer counts elapsed WAIT cycles; the last of TIMEOUT cycles still accepts valido
        WAIT: begin
          if (valido) begin
            rsp_data <= data_out;
            rsp_err  <= 1'b0;
            state    <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= RESP;
          end else begin
            timer    <= timer + TW'(1);
          end
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAC_SEQ_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_done    <= '0;
      stat_timeout <= '0;
    end else if (xfer) begin
      if (rsp_err) stat_timeout <= stat_timeout + 32'd1;
      else         stat_done    <= stat_done + 32'd1;
    end
  end
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_mac_seq_arbiter.sv
// Randomized bench for mac_seq_arbiter: transaction-level model of arbitration, beat timing and responses.
module tb_mac_seq_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req;
  logic [N-1:0][DW-1:0] op_a, op_b, op_c;
  logic [N-1:0]         gnt;
  logic                 validi;
  logic [DW-1:0]        data_in;
  logic                 valido;
  logic [DW-1:0]        data_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IW-1:0]        rsp_id;
  logic [DW-1:0]        rsp_data;
  logic                 rsp_err;
`ifdef MAC_SEQ_ARBITER_STATS_EN
  logic [31:0]          stat_done, stat_timeout;
`endif

  always #5 clk = ~clk;

  mac_seq_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .gnt(gnt), .validi(validi), .data_in(data_in), .valido(valido), .data_out(data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err)
`ifdef MAC_SEQ_ARBITER_STATS_EN
    , .stat_done(stat_done), .stat_timeout(stat_timeout)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // requester side of the model
  bit            pend[N];
  logic [DW-1:0] ra[N], rb[N], rc[N];
  int            ptr_m;
  // in-flight transaction: grant cycle, operands, datapath delay after the c beat
  bit            busy;
  int            cyc, g_cyc, win, dly, resp_cyc;
  logic [DW-1:0] ta, tb, tc, exp_data, last_data;
  logic          exp_err, last_err;
  int            req_pct, rdy_pct, fix_dly;
  int            n_done, n_to;
  int            gnt_log[$];
  int            rsp_log[$];

  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      int k;
      k = (ptr_m + i) % N;
      if (pend[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    pend[i] = 1'b1; ra[i] = a; rb[i] = b; rc[i] = c;
  endtask

  // One clock cycle: drive at negedge, check just after, advance the model for the coming posedge.
  task automatic step(input bit rst_low);
    int           w;
    logic [N-1:0] eg;
    bit           in_beat, in_wait, rv_exp;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (!pend[i] && req_pct > 0 && int'($urandom_range(99)) < req_pct)
        set_req(i, $urandom, $urandom, $urandom);
    for (int i = 0; i < N; i++) begin
      req[i] = pend[i]; op_a[i] = ra[i]; op_b[i] = rb[i]; op_c[i] = rc[i];
    end
    in_beat = busy && cyc >= g_cyc + 1 && cyc <= g_cyc + 3;
    in_wait = busy && cyc > g_cyc + 3 && cyc < resp_cyc;
    if (busy && dly <= TO && cyc == g_cyc + 3 + dly) begin
      valido = 1'b1; data_out = ta * tb + tc;
    end else if (!busy || cyc <= g_cyc + 2 || cyc >= resp_cyc) begin
      valido = 1'($urandom_range(1)); data_out = $urandom;
    end else begin
      valido = 1'b0; data_out = $urandom;
    end
    rsp_ready = int'($urandom_range(99)) < rdy_pct;
    rst = !rst_low;
    #1;
    w = busy ? -1 : pick();
    if (!rst_low) begin
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      chk("gnt", gnt, eg);
      chk("validi", validi, in_beat);
      if (in_beat) chk("data_in", data_in, (cyc == g_cyc + 1) ? ta : (cyc == g_cyc + 2) ? tb : tc);
      if (in_wait) chk("data_in_wait", data_in, 0);
      rv_exp = busy && cyc >= resp_cyc;
      chk("rsp_valid", rsp_valid, rv_exp);
      if (rv_exp) begin
        chk("rsp_id", rsp_id, win);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", rsp_err, exp_err);
      end
    end
    if (rst_low) begin
      busy = 1'b0; ptr_m = 0; n_done = 0; n_to = 0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
    end else if (w >= 0) begin
      busy = 1'b1; g_cyc = cyc; win = w;
      ta = ra[w]; tb = rb[w]; tc = rc[w];
      pend[w] = 1'b0;
      ptr_m = (w + 1) % N;
      if (fix_dly >= 0) dly = fix_dly;
      else dly = ($urandom_range(3) == 0) ? TO + 1 : int'($urandom_range(TO));
      exp_err  = dly > TO;
      exp_data = exp_err ? '0 : ta * tb + tc;
      resp_cyc = cyc + 4 + (exp_err ? TO : dly);
      gnt_log.push_back(w);
    end else if (busy && cyc >= resp_cyc && rsp_ready) begin
      busy = 1'b0;
      rsp_log.push_back(win);
      last_data = rsp_data;
      last_err  = rsp_err;
      if (exp_err) n_to++; else n_done++;
    end
    cyc++;
  endtask

  task automatic run_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((busy || any_pend()) && n < budget) begin
      step(1'b0);
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    int n;
    req_pct = 0; rdy_pct = 100; fix_dly = 0;
    busy = 1'b0; ptr_m = 0; cyc = 0; g_cyc = 0; win = 0; dly = 0; resp_cyc = 0;
    n_done = 0; n_to = 0; last_data = '0; last_err = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; ra[i] = '0; rb[i] = '0; rc[i] = '0; end
    req = '0; op_a = '0; op_b = '0; op_c = '0; valido = 1'b0; data_out = '0;
    rsp_ready = 1'b1; rst = 1'b0;

    // reset state
    step(1'b1); step(1'b1);
    @(posedge clk); #1;
    chk("rst_validi", validi, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);

    // single uncontended request, result with the c beat
    set_req(0, 3, 4, 5); fix_dly = 0;
    run_idle(40, "single_bound");
    chk("single_data", last_data, 17);
    chk("single_err", last_err, 0);

    // 32-bit truncation passes through
    set_req(1, 32'h0001_0000, 32'h0001_0000, 1); fix_dly = 2;
    run_idle(40, "wrap_bound");
    chk("wrap_data", last_data, 32'h0000_0001);

    // datapath never answers
    set_req(2, 7, 8, 9); fix_dly = TO + 1;
    run_idle(40, "timeout_bound");
    chk("timeout_err", last_err, 1);
    chk("timeout_data", last_data, 0);

    // backpressure with a second requester waiting
    fix_dly = 0; rdy_pct = 0;
    set_req(3, 11, 12, 13); set_req(0, 2, 2, 2);
    n = 0;
    while (!(busy && cyc >= resp_cyc) && n < 20) begin step(1'b0); n++; end
    repeat (5) step(1'b0);
    chk("bp_still_pending", rsp_valid, 1);
    rdy_pct = 100;
    run_idle(60, "bp_bound");
    chk("bp_last_id", rsp_log[$], 0);

    // reset in the middle of the beat sequence
    set_req(1, 21, 22, 23); fix_dly = 0;
    n = 0;
    while (!busy && n < 10) begin step(1'b0); n++; end
    step(1'b0);
    step(1'b1);
    @(posedge clk); #1;
    chk("rstmid_validi", validi, 0);
    chk("rstmid_data_in", data_in, 0);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    set_req(0, 1, 1, 1); set_req(2, 5, 6, 7);
    step(1'b0);
    chk("rstmid_first_gnt", gnt_log[$], 0);
    run_idle(60, "rstmid_bound");

    // all requesters continuously
    step(1'b1);
    gnt_log.delete(); rsp_log.delete();
    req_pct = 100; fix_dly = 0; rdy_pct = 100;
    n = 0;
    while (gnt_log.size() < 5 && n < 100) begin step(1'b0); n++; end
    req_pct = 0;
    run_idle(100, "cont_bound");
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
      chk("cont_gnt_order", gnt_log[i], i % N);
      if (i < rsp_log.size()) chk("cont_rsp_order", rsp_log[i], gnt_log[i]);
    end
    chk("cont_count", gnt_log.size() >= 5, 1);

    // randomized traffic, delays and backpressure
    req_pct = 30; rdy_pct = 60; fix_dly = -1;
    repeat (800) step(1'b0);
    req_pct = 0;
    run_idle(300, "rand_bound");

`ifdef MAC_SEQ_ARBITER_STATS_EN
    #1;
    chk("stat_done", stat_done, n_done);
    chk("stat_timeout", stat_timeout, n_to);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
